// File: rtl/blink_led_pkg.sv
// rtl/blink_led_pkg.sv - shared types and helpers for the multi-channel LED blinker
// Contents:
//   mode_e        : channel mode (OFF, ON, BLINK, ONESHOT)
//   ch_cfg_t      : channel configuration (mode, period, on), fields CFG_W wide
//   calc_tick_div : clock cycles per timebase tick
//   led_level     : LED level for a given phase under a given configuration
package blink_led_pkg;

  // Period/on-time fields are carried at this fixed width; instances use PER_W <= CFG_W.
  localparam int CFG_W = 16;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e            mode;
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] on;
  } ch_cfg_t;

  function automatic int calc_tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // period==0 holds the LED low; on>=period holds it high because phase<period.
  function automatic logic led_level(input logic [CFG_W-1:0] phase, input ch_cfg_t c);
    return (c.period != '0) && (phase < c.on);
  endfunction

endpackage

// File: rtl/blink_led_ch.sv
// rtl/blink_led_ch.sv - one LED channel: OFF/ON/BLINK and optional ONESHOT sequencing
// Optional feature macro: BLINK_LED_ONESHOT_EN (enables mode 3 one-shot; otherwise mode 3 acts as OFF)
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   tick     : shared timebase pulse, one cycle wide
//   wr       : accepted configuration write addressed to this channel
//   cfg      : configuration carried by the write
//   led      : registered LED drive
//   busy     : registered one-shot-in-progress flag
module blink_led_ch
  import blink_led_pkg::*;
#(
  parameter int PER_W = 12
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    tick,
  input  logic    wr,
  input  ch_cfg_t cfg,
  output logic    led,
  output logic    busy
);

  ch_cfg_t          act_q, act_d;     // configuration currently driving the pattern
  ch_cfg_t          shd_q, shd_d;     // BLINK rewrite waiting for the next phase wrap
  logic             shd_vld_q, shd_vld_d;
  logic [PER_W-1:0] phase_q, phase_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic             running;
  logic             wrap;

  assign running = (act_q.mode == MODE_BLINK) || (act_q.mode == MODE_ONESHOT);
  // A zero period wraps on every tick so a pending shadow still gets applied.
  assign wrap    = (act_q.period == '0) ||
                   ((CFG_W'(phase_q) + CFG_W'(1)) == act_q.period);

  always_comb begin
    act_d     = act_q;
    shd_d     = shd_q;
    shd_vld_d = shd_vld_q;
    phase_d   = phase_q;
    led_d     = led_q;
    busy_d    = busy_q;

    if (running && tick) begin
      if (wrap) begin
        phase_d = '0;
        if (act_q.mode == MODE_ONESHOT) begin
          act_d.mode = MODE_OFF;
          led_d      = 1'b0;
          busy_d     = 1'b0;
        end else if (shd_vld_q) begin
          act_d     = shd_q;
          shd_vld_d = 1'b0;
          led_d     = led_level('0, shd_q);
        end else begin
          led_d = led_level('0, act_q);
        end
      end else begin
        phase_d = phase_q + PER_W'(1);
        led_d   = led_level(CFG_W'(phase_q) + CFG_W'(1), act_q);
      end
    end

    // A write is evaluated after the tick so it takes precedence in the same cycle;
    // a BLINK-over-BLINK write only lands in the shadow and leaves the pattern alone.
    if (wr) begin
      case (cfg.mode)
        MODE_ON: begin
          act_d     = cfg;
          phase_d   = '0;
          led_d     = 1'b1;
          busy_d    = 1'b0;
          shd_vld_d = 1'b0;
        end
        MODE_BLINK: begin
          if (act_q.mode == MODE_BLINK) begin
            shd_d     = cfg;
            shd_vld_d = 1'b1;
          end else begin
            act_d     = cfg;
            phase_d   = '0;
            led_d     = led_level('0, cfg);
            busy_d    = 1'b0;
            shd_vld_d = 1'b0;
          end
        end
`ifdef BLINK_LED_ONESHOT_EN
        MODE_ONESHOT: begin
          act_d     = cfg;
          phase_d   = '0;
          led_d     = led_level('0, cfg);
          busy_d    = 1'b1;
          shd_vld_d = 1'b0;
        end
`endif
        default: begin
          act_d      = cfg;
          act_d.mode = MODE_OFF;
          phase_d    = '0;
          led_d      = 1'b0;
          busy_d     = 1'b0;
          shd_vld_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q     <= '0;
      shd_q     <= '0;
      shd_vld_q <= 1'b0;
      phase_q   <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      act_q     <= act_d;
      shd_q     <= shd_d;
      shd_vld_q <= shd_vld_d;
      phase_q   <= phase_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: rtl/blink_led_multi_ch.sv
// rtl/blink_led_multi_ch.sv - multi-channel LED blinker top: shared prescaler, config handshake, channels
// Optional feature macro: BLINK_LED_ONESHOT_EN (passed through to blink_led_ch)
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   cfg_valid  : configuration request
//   cfg_ready  : configuration accept (low during reset and in the cycle after a transfer)
//   cfg_ch     : target channel (values >= NUM_CH are accepted and ignored)
//   cfg_mode   : 0 OFF, 1 ON, 2 BLINK, 3 ONESHOT
//   cfg_period : period in ticks
//   cfg_on     : on-time in ticks
//   led        : registered LED drive per channel
//   ch_busy    : registered one-shot-in-progress per channel
module blink_led_multi_ch
  import blink_led_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int TICK_FREQ_HZ = 1_000,
  parameter int NUM_CH       = 4,
  parameter int PER_W        = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic [PER_W-1:0]  cfg_on,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] ch_busy
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ_HZ, TICK_FREQ_HZ);
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] pre_q;
  logic             tick;
  logic             xfer;
  logic             xfer_q;
  ch_cfg_t          cfg;

  assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

  // Ready is forced low by rst directly so it rises in the very first cycle after release.
  assign cfg_ready = !rst && !xfer_q;
  assign xfer      = cfg_valid && cfg_ready;

  assign cfg = '{mode: mode_e'(cfg_mode), period: CFG_W'(cfg_period), on: CFG_W'(cfg_on)};

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      xfer_q <= 1'b0;
    end else begin
      pre_q  <= tick ? '0 : pre_q + PRE_W'(1);
      xfer_q <= xfer;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    blink_led_ch #(
      .PER_W (PER_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .wr   (xfer && (cfg_ch == 4'(i))),
      .cfg  (cfg),
      .led  (led[i]),
      .busy (ch_busy[i])
    );
  end

endmodule

// File: tb/tb_blink_led_multi_ch.sv
// tb/tb_blink_led_multi_ch.sv - directed self-checking bench for blink_led_multi_ch
// Optional feature macro: BLINK_LED_ONESHOT_EN (selects one-shot expectations)
module tb_blink_led_multi_ch;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_period;
  logic [7:0] cfg_on;
  logic [3:0] led;
  logic [3:0] ch_busy;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int s0, s1, s3;
  bit on0, on1, on3, e2;

  blink_led_multi_ch #(
    .CLK_FREQ_HZ  (1000),
    .TICK_FREQ_HZ (100),
    .NUM_CH       (4),
    .PER_W        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_on     (cfg_on),
    .led        (led),
    .ch_busy    (ch_busy)
  );

  always #5 clk = ~clk;

  // Edges since reset release; tick edges are those that leave cyc % 10 == 0.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [3:0] exp_led();
    logic [3:0] e;
    int i;
    e = 4'b0000;
    if (on0) e[0] = ((cyc - s0) % 40) < 10;
    if (on1) begin
      i = cyc - s1;
      e[1] = (i < 40) ? ((i % 40) < 20) : (((i - 40) % 60) < 30);
    end
    e[2] = e2;
`ifdef BLINK_LED_ONESHOT_EN
    if (on3) e[3] = (cyc - s3) < 20;
`endif
    return e;
  endfunction

  function automatic logic [3:0] exp_busy();
    logic [3:0] e;
    e = 4'b0000;
`ifdef BLINK_LED_ONESHOT_EN
    if (on3) e[3] = (cyc - s3) < 30;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      check("led", 32'(led), 32'(exp_led()));
      check("busy", 32'(ch_busy), 32'(exp_busy()));
    end
  endtask

  // Stop at a negedge just before a tick edge so the next transfer starts on a tick.
  task automatic align();
    run(1);
    while (cyc % 10 != 9) run(1);
  endtask

  task automatic xfer(input logic [3:0] ch, input logic [1:0] mode,
                      input logic [7:0] per, input logic [7:0] on);
    check("xfer_ready", 32'(cfg_ready), 32'd1);
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = per;
    cfg_on     = on;
    cfg_valid  = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_period = '0; cfg_on = '0;
    on0 = 0; on1 = 0; on3 = 0; e2 = 0; s0 = 0; s1 = 0; s3 = 0;

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_led", 32'(led), 32'd0);
    check("rst_busy", 32'(ch_busy), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(cfg_ready), 32'd1);
    run(5);

    // ch0 BLINK period 4 on 1
    align();
    xfer(4'd0, 2'd2, 8'd4, 8'd1); s0 = cyc; on0 = 1;
    run(80);

    // ch1 BLINK 4/2, then 6/3 written during phase 1
    run(2); align();
    xfer(4'd1, 2'd2, 8'd4, 8'd2); s1 = cyc; on1 = 1;
    run(12);
    xfer(4'd1, 2'd2, 8'd6, 8'd3);
    run(130);

    // ch2 boundaries: period 0, on==period, on 0
    run(2);
    xfer(4'd2, 2'd2, 8'd0, 8'd3); e2 = 0;
    run(25);
    xfer(4'd2, 2'd0, 8'd0, 8'd0);
    run(2);
    xfer(4'd2, 2'd2, 8'd5, 8'd5); e2 = 1;
    run(60);
    xfer(4'd2, 2'd0, 8'd0, 8'd0); e2 = 0;
    run(2);
    xfer(4'd2, 2'd2, 8'd5, 8'd0);
    run(30);

    // Back-to-back requests to a nonexistent channel
    run(2);
    cfg_ch = 4'd7; cfg_mode = 2'd1; cfg_period = 8'd4; cfg_on = 8'd2; cfg_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("b2b_ready", 32'(cfg_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("b2b_led", 32'(led), 32'(exp_led()));
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    run(2);

    // ch3 ONESHOT period 3 on 2
    align();
    xfer(4'd3, 2'd3, 8'd3, 8'd2); s3 = cyc; on3 = 1;
    run(50);

    // Reset in the middle of a one-shot and blinks
    run(2); align();
    xfer(4'd3, 2'd3, 8'd3, 8'd2); s3 = cyc;
    run(15);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_led", 32'(led), 32'd0);
      check("mid_rst_busy", 32'(ch_busy), 32'd0);
      check("mid_rst_ready", 32'(cfg_ready), 32'd0);
    end
    rst = 1'b0; on0 = 0; on1 = 0; on3 = 0; e2 = 0;
    #1;
    check("mid_ready_after_rst", 32'(cfg_ready), 32'd1);
    run(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blink_led_multi_ch.md
BLINK_LED_MULTI_CH -- requirements
Module: blink_led_multi_ch

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, input clock frequency.
REQ-002 SHALL have parameter TICK_FREQ_HZ, default 1_000, timebase tick rate; TICK_DIV = CLK_FREQ_HZ/TICK_FREQ_HZ, which shall be 2 or more.
REQ-003 SHALL have parameter NUM_CH, default 4, number of LED channels, range 1..16.
REQ-004 SHALL have parameter PER_W, default 12, width of the period and on-time fields, in ticks.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port cfg_valid, input, 1, config request.
REQ-008 SHALL have port cfg_ready, output, 1, config accept.
REQ-009 SHALL have port cfg_ch, input, 4, target channel.
REQ-010 SHALL have port cfg_mode, input, 2, mode: 0 OFF, 1 ON, 2 BLINK, 3 ONESHOT.
REQ-011 SHALL have port cfg_period, input, PER_W, period in ticks.
REQ-012 SHALL have port cfg_on, input, PER_W, on-time in ticks.
REQ-013 SHALL have port led, output, NUM_CH, active-high LED drive, registered.
REQ-014 SHALL have port ch_busy, output, NUM_CH, one-shot in progress, registered.

Function
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick is a 1-cycle pulse when count==TICK_DIV-1; the prescaler is shared by all channels.
REQ-016 A transfer SHALL occur when cfg_valid&&cfg_ready; cfg_ready SHALL be 1 in every cycle except the cycle after a transfer, giving a 1-cycle busy.
REQ-017 A transfer with cfg_ch>=NUM_CH SHALL be accepted and ignored, with no state change.
REQ-018 Accepted OFF/ON SHALL apply at once: led[ch] is 0 (OFF) or 1 (ON) from the cycle after transfer; the phase counter is cleared.
REQ-019 Accepted BLINK from OFF/ON SHALL set phase=0 and load period/on, with led[ch]=(cfg_on>0) from the cycle after transfer.
REQ-020 Accepted BLINK while already BLINK SHALL go to a shadow register and apply at the next phase wrap; no truncated or glitched pulse is allowed; a later write before the wrap overwrites the shadow.
REQ-021 In BLINK, phase SHALL advance on each tick 0..period-1, then wrap; led[ch] SHALL be registered from phase<on.
REQ-022 Boundaries: period==0 SHALL give led held 0; on>=period SHALL give led held 1; on==0 SHALL give led held 0.
REQ-023 Channels SHALL be fully independent; a transfer to one channel SHALL NOT disturb another channel's phase.
REQ-024 Phase and period arithmetic SHALL be unsigned PER_W-bit with no overflow, because phase<period always holds.

Reset
REQ-025 While rst=1 at a clk edge, SHALL set: prescaler=0, all channels OFF, phase=0, shadows cleared, led=0, ch_busy=0, cfg_ready=0.
REQ-026 cfg_ready SHALL be 1 in the first cycle after rst is released.
REQ-027 Reset mid-blink or mid-one-shot SHALL abort immediately, with no residual pulse.

Configuration
REQ-028 Macro BLINK_LED_ONESHOT_EN SHALL control the ONESHOT feature.
REQ-029 With BLINK_LED_ONESHOT_EN defined, mode 3 SHALL run exactly one period as in BLINK from phase 0 with ch_busy[ch]=1, then at the wrap go to OFF with ch_busy=0.
REQ-030 With BLINK_LED_ONESHOT_EN defined, a rewrite during a one-shot SHALL apply immediately per REQ-018/019 and clear ch_busy.
REQ-031 Without BLINK_LED_ONESHOT_EN, mode 3 SHALL be treated as OFF and ch_busy SHALL be constant 0.

Structure
REQ-032 Package blink_led_pkg SHALL hold the mode enum (OFF, ON, BLINK, ONESHOT), the channel-config struct (mode, period, on), and the TICK_DIV calculation function.
REQ-033 Per-channel logic SHALL be the sub-module blink_led_ch, instantiated NUM_CH times by generate; the prescaler and handshake logic live in the top module.

Verification
All scenarios use CLK_FREQ_HZ=1000, TICK_FREQ_HZ=100 (TICK_DIV=10), NUM_CH=4, PER_W=8.
REQ-034 Reset: rst high for 3 cycles, mid-operation -> led=0, ch_busy=0, cfg_ready=0 during reset; cfg_ready=1 in the first cycle after release.
REQ-035 BLINK ch0, period=4, on=1 -> led[0] is high 10 cycles and low 30 cycles, repeating; led[3:1] stay 0.
REQ-036 While ch1 is BLINK with period 4/on 2, write period 6/on 3 at phase 1 -> the current 4-tick period completes unchanged, then the 6-tick pattern starts.
REQ-037 Boundaries: ch2 with period=0 -> led 0; on=5/period=5 -> led 1; cfg_ch=7 -> accepted, no change; back-to-back cfg_valid -> every second cycle accepted.
REQ-038 ONESHOT ch3, period=3, on=2 with BLINK_LED_ONESHOT_EN defined -> led high 20 cycles, busy for 30 cycles, then OFF; without the macro -> led stays 0 and busy stays 0.
